spi_flash_read_arb: RTL and testbench

SPI_FLASH_READ_ARB -- requirements
Module: spi_flash_read_arb

---
 rtl/spi_flash_read_arb.sv | 154 +++++++++++++++
 tb/tb_spi_flash_read_arb.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/spi_flash_read_arb.sv
// Two-requester AXI4 read arbiter in front of a single SPI flash read port; one burst in flight.
// Define SPI_FLASH_ARB_FIXED_PRIO_EN for fixed priority (requester 0 wins) instead of round-robin.
module spi_flash_read_arb #(
    parameter int AddrWidth = 24,
    parameter int DataWidth = 32,
    parameter int IdWidth   = 1
) (
    input  logic                 clk_i,
    input  logic                 rst_i,

    input  logic                 r0_ar_valid,
    output logic                 r0_ar_ready,
    input  logic [AddrWidth-1:0] r0_ar_addr,
    input  logic [7:0]           r0_ar_len,
    input  logic [IdWidth-1:0]   r0_ar_id,
    output logic                 r0_r_valid,
    input  logic                 r0_r_ready,
    output logic [DataWidth-1:0] r0_r_data,
    output logic [IdWidth-1:0]   r0_r_id,
    output logic [1:0]           r0_r_resp,
    output logic                 r0_r_last,

    input  logic                 r1_ar_valid,
    output logic                 r1_ar_ready,
    input  logic [AddrWidth-1:0] r1_ar_addr,
    input  logic [7:0]           r1_ar_len,
    input  logic [IdWidth-1:0]   r1_ar_id,
    output logic                 r1_r_valid,
    input  logic                 r1_r_ready,
    output logic [DataWidth-1:0] r1_r_data,
    output logic [IdWidth-1:0]   r1_r_id,
    output logic [1:0]           r1_r_resp,
    output logic                 r1_r_last,

    output logic                 dev_ar_valid,
    input  logic                 dev_ar_ready,
    output logic [AddrWidth-1:0] dev_ar_addr,
    output logic [7:0]           dev_ar_len,
    output logic [IdWidth-1:0]   dev_ar_id,
    output logic [2:0]           dev_ar_size,
    output logic [1:0]           dev_ar_burst,
    input  logic                 dev_r_valid,
    output logic                 dev_r_ready,
    input  logic [DataWidth-1:0] dev_r_data,
    input  logic [IdWidth-1:0]   dev_r_id,
    input  logic [1:0]           dev_r_resp,
    input  logic                 dev_r_last,

    output logic                 busy_o,
    output logic                 grant_o
);

    typedef enum logic [1:0] {IDLE, ADDR, DATA} state_e;

    state_e                 state_q, state_d;
    logic                   grant_q, grant_d;
    logic [AddrWidth-1:0]   addr_q, addr_d;
    logic [7:0]             len_q, len_d;
    logic [IdWidth-1:0]     id_q, id_d;
    logic [1:0]             ar_valid;
    logic                   win;
    logic                   do_grant;
    logic                   in_data;

    assign ar_valid = {r1_ar_valid, r0_ar_valid};

`ifdef SPI_FLASH_ARB_FIXED_PRIO_EN
    assign win = ~r0_ar_valid;
`else
    logic rr_ptr_q, rr_ptr_d;
    // rr_ptr_q holds the last winner; on contention the other requester goes next.
    assign win = (&ar_valid) ? ~rr_ptr_q : r1_ar_valid;
`endif

    assign do_grant = (state_q == IDLE) && (|ar_valid) && !rst_i;
    assign in_data  = (state_q == DATA);

    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
        state_d  = state_q;
        grant_d  = grant_q;
        addr_d   = addr_q;
        len_d    = len_q;
        id_d     = id_q;
`ifndef SPI_FLASH_ARB_FIXED_PRIO_EN
        rr_ptr_d = rr_ptr_q;
`endif
        case (state_q)
            IDLE: if (do_grant) begin
                state_d  = ADDR;
                grant_d  = win;
`ifndef SPI_FLASH_ARB_FIXED_PRIO_EN
                rr_ptr_d = win;
`endif
                addr_d   = win ? r1_ar_addr : r0_ar_addr;
                len_d    = win ? r1_ar_len  : r0_ar_len;
                id_d     = win ? r1_ar_id   : r0_ar_id;
            end
            ADDR: if (dev_ar_ready) state_d = DATA;
            DATA: if (dev_r_valid && dev_r_ready && dev_r_last) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        // NOTE: non-blocking assignments so every flop samples the pre-edge values.
        if (rst_i) begin
            state_q  <= IDLE;
            grant_q  <= 1'b0;
            addr_q   <= '0;
            len_q    <= '0;
            id_q     <= '0;
`ifndef SPI_FLASH_ARB_FIXED_PRIO_EN
            rr_ptr_q <= 1'b1;
`endif
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            addr_q   <= addr_d;
            len_q    <= len_d;
            id_q     <= id_d;
`ifndef SPI_FLASH_ARB_FIXED_PRIO_EN
            rr_ptr_q <= rr_ptr_d;
`endif
        end
    end

    assign r0_ar_ready  = do_grant && !win;
    assign r1_ar_ready  = do_grant && win;

    assign dev_ar_valid = (state_q == ADDR);
    assign dev_ar_addr  = addr_q;
    assign dev_ar_len   = len_q;
    assign dev_ar_id    = id_q;
    assign dev_ar_size  = 3'($clog2(DataWidth / 8));
    assign dev_ar_burst = 2'b01;

    // R channel is a pure combinational steer: no added latency.
    assign dev_r_ready  = in_data && (grant_q ? r1_r_ready : r0_r_ready);
    assign r0_r_valid   = in_data && !grant_q && dev_r_valid;
    assign r1_r_valid   = in_data &&  grant_q && dev_r_valid;
    assign r0_r_data    = dev_r_data;
    assign r1_r_data    = dev_r_data;
    assign r0_r_id      = dev_r_id;
    assign r1_r_id      = dev_r_id;
    assign r0_r_resp    = dev_r_resp;
    assign r1_r_resp    = dev_r_resp;
    assign r0_r_last    = dev_r_last;
    assign r1_r_last    = dev_r_last;

    assign busy_o  = (state_q != IDLE);
    assign grant_o = grant_q;

endmodule

// File: tb/tb_spi_flash_read_arb.sv
// Directed bench for spi_flash_read_arb: arbitration order, AR hold, R steering, error pass-through, reset.
module tb_spi_flash_read_arb;

    logic                   clk_i = 1'b0;
    logic                   rst_i = 1'b1;
    logic [1:0]             ar_valid = '0;
    logic [1:0]             ar_ready;
    logic [1:0][23:0]       ar_addr = '0;
    logic [1:0][7:0]        ar_len = '0;
    logic [1:0]             ar_id = '0;
    logic [1:0]             r_valid;
    logic [1:0]             r_ready = '0;
    logic [1:0][31:0]       r_data;
    logic [1:0]             r_id;
    logic [1:0][1:0]        r_resp;
    logic [1:0]             r_last;
    logic                   dev_ar_valid;
    logic                   dev_ar_ready = 1'b0;
    logic [23:0]            dev_ar_addr;
    logic [7:0]             dev_ar_len;
    logic                   dev_ar_id;
    logic [2:0]             dev_ar_size;
    logic [1:0]             dev_ar_burst;
    logic                   dev_r_valid = 1'b0;
    logic                   dev_r_ready;
    logic [31:0]            dev_r_data = '0;
    logic                   dev_r_id = 1'b0;
    logic [1:0]             dev_r_resp = '0;
    logic                   dev_r_last = 1'b0;
    logic                   busy_o;
    logic                   grant_o;

    int n_cmp = 0;
    int n_err = 0;

    spi_flash_read_arb dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .r0_ar_valid(ar_valid[0]), .r0_ar_ready(ar_ready[0]), .r0_ar_addr(ar_addr[0]),
        .r0_ar_len(ar_len[0]), .r0_ar_id(ar_id[0]),
        .r0_r_valid(r_valid[0]), .r0_r_ready(r_ready[0]), .r0_r_data(r_data[0]),
        .r0_r_id(r_id[0]), .r0_r_resp(r_resp[0]), .r0_r_last(r_last[0]),
        .r1_ar_valid(ar_valid[1]), .r1_ar_ready(ar_ready[1]), .r1_ar_addr(ar_addr[1]),
        .r1_ar_len(ar_len[1]), .r1_ar_id(ar_id[1]),
        .r1_r_valid(r_valid[1]), .r1_r_ready(r_ready[1]), .r1_r_data(r_data[1]),
        .r1_r_id(r_id[1]), .r1_r_resp(r_resp[1]), .r1_r_last(r_last[1]),
        .dev_ar_valid(dev_ar_valid), .dev_ar_ready(dev_ar_ready), .dev_ar_addr(dev_ar_addr),
        .dev_ar_len(dev_ar_len), .dev_ar_id(dev_ar_id), .dev_ar_size(dev_ar_size),
        .dev_ar_burst(dev_ar_burst),
        .dev_r_valid(dev_r_valid), .dev_r_ready(dev_r_ready), .dev_r_data(dev_r_data),
        .dev_r_id(dev_r_id), .dev_r_resp(dev_r_resp), .dev_r_last(dev_r_last),
        .busy_o(busy_o), .grant_o(grant_o)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    // Requester g issues one burst, then the device model answers it. Returns in the IDLE
    // cycle that follows the last handshake. err_beat < 0 means no error beat.
    task automatic run_burst(input int g, input logic [23:0] addr, input logic [7:0] len,
                             input int ar_delay, input bit toggle, input int err_beat,
                             input bit keep);
        int o;
        int beat;
        int cyc;
        logic [31:0] exp_data;
        o = 1 - g;
        ar_valid[g] = 1'b1;
        ar_addr[g]  = addr;
        ar_len[g]   = len;
        ar_id[g]    = g[0];
        #1;
        check("ar_ready_winner", ar_ready[g], 1);
        check("ar_ready_loser", ar_ready[o], 0);
        step();
        if (!keep) ar_valid[g] = 1'b0;
        dev_r_valid = 1'b1;
        for (int k = 0; k <= ar_delay; k++) begin
            dev_ar_ready = (k == ar_delay);
            #1;
            check("addr_dev_ar_valid", dev_ar_valid, 1);
            check("addr_dev_ar_addr", dev_ar_addr, addr);
            check("addr_dev_ar_len", dev_ar_len, len);
            check("addr_dev_ar_id", dev_ar_id, g[0]);
            check("addr_grant_o", grant_o, g[0]);
            check("addr_busy", busy_o, 1);
            check("addr_ar_ready", ar_ready, 2'b00);
            check("addr_r_valid", r_valid, 2'b00);
            check("addr_dev_r_ready", dev_r_ready, 0);
            step();
        end
        dev_ar_ready = 1'b0;
        beat = 0;
        cyc  = 0;
        while (beat <= int'(len) && cyc < 64) begin
            r_ready[g] = toggle ? ~cyc[0] : 1'b1;
            r_ready[o] = ~r_ready[g];
            exp_data   = {addr[15:0], 8'(g), 8'(beat)};
            dev_r_data = exp_data;
            dev_r_id   = g[0];
            dev_r_resp = (beat == err_beat) ? 2'b10 : 2'b00;
            dev_r_last = (beat == int'(len));
            #1;
            check("data_dev_r_ready", dev_r_ready, r_ready[g]);
            check("data_r_valid_granted", r_valid[g], 1);
            check("data_r_valid_other", r_valid[o], 0);
            check("data_r_data", r_data[g], exp_data);
            check("data_r_id", r_id[g], g[0]);
            check("data_r_resp", r_resp[g], (beat == err_beat) ? 2'b10 : 2'b00);
            check("data_r_last", r_last[g], (beat == int'(len)) ? 1 : 0);
            check("data_busy", busy_o, 1);
            if (r_ready[g]) beat++;
            cyc++;
            step();
        end
        if (beat <= int'(len)) check("burst_timeout", 0, 1);
        dev_r_valid = 1'b0;
        dev_r_last  = 1'b0;
        dev_r_resp  = 2'b00;
        r_ready     = 2'b00;
        check("idle_after_last", busy_o, 0);
        check("idle_dev_r_ready", dev_r_ready, 0);
    endtask

    initial begin
        // Reset with both requesters already asking: nothing may be granted yet.
        ar_valid = 2'b11;
        step();
        step();
        check("rst_busy", busy_o, 0);
        check("rst_dev_ar_valid", dev_ar_valid, 0);
        check("rst_dev_r_ready", dev_r_ready, 0);
        check("rst_ar_ready", ar_ready, 2'b00);
        check("rst_r_valid", r_valid, 2'b00);
        check("rst_grant_o", grant_o, 0);
        check("const_ar_size", dev_ar_size, 3'd2);
        check("const_ar_burst", dev_ar_burst, 2'b01);

        // Simultaneous requests: r0 first, r1 in the IDLE cycle after r0's last beat.
        ar_addr[1] = 24'h000200;
        ar_len[1]  = 8'd3;
        ar_id[1]   = 1'b1;
        rst_i = 1'b0;
        run_burst(0, 24'h000100, 8'd3, 0, 1'b0, -1, 1'b0);
        run_burst(1, 24'h000200, 8'd3, 0, 1'b0, -1, 1'b0);

        // r1 alone, single beat, device accepts AR only after 4 wait cycles.
        run_burst(1, 24'h00ABCD, 8'd0, 4, 1'b0, -1, 1'b0);

        // r0, 8 beats, r0_r_ready toggling every cycle.
        run_burst(0, 24'h001000, 8'd7, 0, 1'b1, -1, 1'b0);

        // SLVERR on beat 2 of 4 forwarded on that beat only; burst runs to completion.
        run_burst(0, 24'h002000, 8'd3, 1, 1'b0, 1, 1'b0);

        // Reset in DATA after the first beat abandons the burst.
        ar_valid[0] = 1'b1;
        ar_addr[0]  = 24'h003000;
        ar_len[0]   = 8'd3;
        ar_id[0]    = 1'b0;
        #1;
        check("mid_ar_ready", ar_ready[0], 1);
        step();
        ar_valid[0]  = 1'b0;
        dev_ar_ready = 1'b1;
        step();
        dev_ar_ready = 1'b0;
        dev_r_valid  = 1'b1;
        dev_r_data   = 32'hCAFE0000;
        r_ready[0]   = 1'b1;
        #1;
        check("mid_beat0_valid", r_valid[0], 1);
        step();
        rst_i = 1'b1;
        dev_r_data = 32'hCAFE0001;
        step();
        rst_i = 1'b0;
        #1;
        check("mid_rst_busy", busy_o, 0);
        check("mid_rst_dev_r_ready", dev_r_ready, 0);
        check("mid_rst_r_valid", r_valid, 2'b00);
        check("mid_rst_grant_o", grant_o, 0);
        check("mid_rst_dev_ar_valid", dev_ar_valid, 0);
        dev_r_valid = 1'b0;
        r_ready     = 2'b00;
        run_burst(1, 24'h004000, 8'd1, 0, 1'b0, -1, 1'b0);

        // Both requesters continuously valid for six bursts; last winner was r1.
        ar_valid = 2'b11;
        for (int b = 0; b < 6; b++) begin
`ifdef SPI_FLASH_ARB_FIXED_PRIO_EN
            run_burst(0, 24'h005000 + 24'(b * 16), 8'd1, 0, 1'b0, -1, 1'b1);
`else
            run_burst(b % 2, 24'h005000 + 24'(b * 16), 8'd1, 0, 1'b0, -1, 1'b1);
`endif
        end
        ar_valid = 2'b00;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
